request_latch: RTL and testbench

Hall- and car-call request register feeding `floorControl`. Ten raw push-button inputs are synchronised, optionally debounced, and edge-detected, then held in a latch. Each held request stays asserted until `floorControl` drives the matching `resetButtons` bit to clear it. The latched bus drives the `C1U..G4` inputs of `floorControl` directly and doubles as the button-lamp drive.

---
 rtl/elevator_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/request_latch.sv | 92 +++++++++
 tb/tb_request_latch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg
// Constants shared between request_latch and floorControl.
//   BTN_N        : width of every button / request bus
//   BTN_*        : bit positions, bus order {C1U,C2D,C2U,C3D,C3U,C4D,G1,G2,G3,G4}
//   CLR_F*_UP/DN : per-floor clear masks; each pairs a hall call with the
//                  car call for that floor
package elevator_pkg;

  localparam int BTN_N = 10;

  localparam int BTN_C1U = 9;
  localparam int BTN_C2D = 8;
  localparam int BTN_C2U = 7;
  localparam int BTN_C3D = 6;
  localparam int BTN_C3U = 5;
  localparam int BTN_C4D = 4;
  localparam int BTN_G1  = 3;
  localparam int BTN_G2  = 2;
  localparam int BTN_G3  = 1;
  localparam int BTN_G4  = 0;

  localparam logic [BTN_N-1:0] CLR_F1_UP = 10'b1000001000;
  localparam logic [BTN_N-1:0] CLR_F2_DN = 10'b0100000100;
  localparam logic [BTN_N-1:0] CLR_F2_UP = 10'b0010000100;
  localparam logic [BTN_N-1:0] CLR_F3_DN = 10'b0001000010;
  localparam logic [BTN_N-1:0] CLR_F3_UP = 10'b0000100010;
  localparam logic [BTN_N-1:0] CLR_F4_DN = 10'b0000010001;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Single-bit debouncer. The output level follows the input only after the
// input has differed from it for DB_CYCLES consecutive cycles; any cycle in
// which the input matches the output restarts the qualification.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   din     : synchronised input level
//   dout    : debounced level
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (din == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/request_latch.sv
// request_latch
// Hall/car-call request register for floorControl. Each raw button is
// synchronised, optionally debounced, rise-detected and latched; a latched
// request holds until floorControl clears it through resetButtons.
// Optional feature macro: REQUEST_LATCH_DEBOUNCE_EN (defined: per-bit
// debouncer with DB_CYCLES qualification; undefined: db taken straight from
// the synchroniser, DB_CYCLES/CNT_W unused apart from the range check).
//   clk          : system clock, rising edge
//   reset_n      : synchronous active-low reset
//   btn_raw      : asynchronous raw button levels, 1 = pressed
//   resetButtons : per-request clear, wins over a same-edge press
//   req          : latched requests (floorControl C1U..G4 and lamps)
//   any_req      : registered OR of req, coincident with req
//   new_req      : one-cycle pulse when any req bit goes 0->1
module request_latch
  import elevator_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BTN_N-1:0] btn_raw,
  input  logic [BTN_N-1:0] resetButtons,
  output logic [BTN_N-1:0] req,
  output logic             any_req,
  output logic             new_req
);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535 || CNT_W < 1) begin : g_bad_db_cycles
    $error("request_latch: DB_CYCLES must lie within 2..65535");
  end

  logic [BTN_N-1:0] s1_q, s1_d;
  logic [BTN_N-1:0] s2_q, s2_d;
  logic [BTN_N-1:0] db;
  logic [BTN_N-1:0] db_prev_q, db_prev_d;
  logic [BTN_N-1:0] rise;
  logic [BTN_N-1:0] req_q, req_d;
  logic             any_req_q, any_req_d;
  logic             new_req_q, new_req_d;

`ifdef REQUEST_LATCH_DEBOUNCE_EN
  for (genvar i = 0; i < BTN_N; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (s2_q[i]),
      .dout    (db[i])
    );
  end
`else
  always_comb db = s2_q;
`endif

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    db_prev_d = db;
    rise      = db & ~db_prev_q;
    // Clear is applied after the OR so a same-edge press on a bit being
    // serviced is dropped rather than re-latched.
    req_d     = (req_q | rise) & ~resetButtons;
    any_req_d = |req_d;
    new_req_d = |(rise & ~resetButtons & ~req_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_prev_q <= '0;
      req_q     <= '0;
      any_req_q <= 1'b0;
      new_req_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_prev_q <= db_prev_d;
      req_q     <= req_d;
      any_req_q <= any_req_d;
      new_req_q <= new_req_d;
    end
  end

  assign req     = req_q;
  assign any_req = any_req_q;
  assign new_req = new_req_q;

endmodule

// File: tb/tb_request_latch.sv
// tb_request_latch
// Scoreboard bench for request_latch: every driven edge pushes the reference
// model's expected {req, any_req, new_req} into a queue; a monitor pops and
// compares one entry per clock, #1 after the rising edge.
module tb_request_latch;
  import elevator_pkg::*;

  localparam int DB = 16;
`ifdef REQUEST_LATCH_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif
  localparam int LAT = DB_ON ? DB + 2 : 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [BTN_N-1:0] btn_raw = '0;
  logic [BTN_N-1:0] resetButtons = '0;
  logic [BTN_N-1:0] req;
  logic             any_req;
  logic             new_req;

  request_latch #(
    .DB_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_raw      (btn_raw),
    .resetButtons (resetButtons),
    .req          (req),
    .any_req      (any_req),
    .new_req      (new_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BTN_N-1:0] req;
    logic             any;
    logic             nw;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  bit          done   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, want);
    end
  endtask

  // Reference model: pipeline of sampled levels, debounced level decided by
  // "the last DB synchronised samples all disagree with the current level".
  logic [BTN_N-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_prev = '0, m_req = '0;
  logic [BTN_N-1:0] hist[$];

  task automatic model_edge(input logic [BTN_N-1:0] raw, input logic [BTN_N-1:0] rb,
                            input logic rstn);
    exp_t             e;
    logic [BTN_N-1:0] cur, rise, old;
    bit               all_diff;
    if (!rstn) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0; m_req = '0;
      hist.delete();
      e = '0;
    end else begin
      cur   = DB_ON ? m_db : m_s2;
      rise  = cur & ~m_prev;
      old   = m_req;
      m_req = (m_req | rise) & ~rb;
      e.req = m_req;
      e.any = |m_req;
      e.nw  = |(m_req & ~old);
      m_prev = cur;
      if (DB_ON) begin
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB) begin
          for (int b = 0; b < BTN_N; b++) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) m_db[b] = ~m_db[b];
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic [BTN_N-1:0] raw, input logic [BTN_N-1:0] rb,
                      input logic rstn);
    btn_raw      = raw;
    resetButtons = rb;
    reset_n      = rstn;
    model_edge(raw, rb, rstn);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    for (int k = 0; k < LAT + 4; k++) step('0, '1, 1'b1);
    for (int k = 0; k < 2; k++) step('0, '0, 1'b1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_req",     32'(req),     32'(e.req));
        check("sb_any_req", 32'(any_req), 32'(e.any));
        check("sb_new_req", 32'(new_req), 32'(e.nw));
      end
    end
  end

  // Stimulus
  initial begin
    logic [BTN_N-1:0] m_g1, m_g3, m_g4, m_c2u, m_c4d, raw, rb, g;
    logic             rstn;
    m_g1  = 10'(1) << BTN_G1;
    m_g3  = 10'(1) << BTN_G3;
    m_g4  = 10'(1) << BTN_G4;
    m_c2u = 10'(1) << BTN_C2U;
    m_c4d = 10'(1) << BTN_C4D;

    // Reset with every button held, then release reset.
    for (int k = 0; k < 5; k++) begin
      step('1, '0, 1'b0);
      check("rst_req", 32'(req), 32'h0);
      check("rst_any", 32'(any_req), 32'h0);
      check("rst_new", 32'(new_req), 32'h0);
    end
    for (int k = 0; k < 30; k++) begin
      step('1, '0, 1'b1);
      if (k == LAT - 1) check("all_pre", 32'(req), 32'h0);
      if (k == LAT) begin
        check("all_req", 32'(req), 32'h3FF);
        check("all_new", 32'(new_req), 32'h1);
      end
    end
    idle();

    // Glitch shorter than the debounce window, then a qualified press.
    for (int k = 0; k < 10; k++) step(m_g3, '0, 1'b1);
    for (int k = 0; k < LAT + 6; k++) step('0, '0, 1'b1);
    if (DB_ON) check("glitch_req", 32'(req), 32'h0);
    idle();
    for (int k = 0; k < 20; k++) begin
      step(m_g3, '0, 1'b1);
      if (k == LAT - 1) check("g3_pre", 32'(req), 32'h0);
      if (k == LAT)     check("g3_req", 32'(req), 32'(m_g3));
    end
    idle();

    // Held button cleared mid-hold must not re-latch until a fresh press.
    for (int k = 0; k < 200; k++) begin
      step(m_c2u, (k == 50) ? m_c2u : '0, 1'b1);
      if (k == 49)  check("held_set", 32'(req[BTN_C2U]), 32'h1);
      if (k == 50)  check("held_clr", 32'(req[BTN_C2U]), 32'h0);
      if (k == 199) check("held_end", 32'(req[BTN_C2U]), 32'h0);
    end
    for (int k = 0; k < LAT + 4; k++) step('0, '0, 1'b1);
    for (int k = 0; k < LAT + 2; k++) step(m_c2u, '0, 1'b1);
    check("held_repress", 32'(req[BTN_C2U]), 32'h1);
    idle();

    // Rise coincident with clear on the same bit, then on a different bit.
    for (int k = 0; k < LAT + 3; k++) begin
      step(m_g1, (k == LAT) ? m_g1 : '0, 1'b1);
      if (k == LAT) begin
        check("same_req", 32'(req), 32'h0);
        check("same_new", 32'(new_req), 32'h0);
      end
    end
    idle();
    for (int k = 0; k < LAT + 3; k++) begin
      step(m_c4d, (k == LAT) ? m_g1 : '0, 1'b1);
      if (k == LAT) begin
        check("diff_req", 32'(req), 32'(m_c4d));
        check("diff_new", 32'(new_req), 32'h1);
      end
    end
    idle();

`ifndef REQUEST_LATCH_DEBOUNCE_EN
    for (int k = 0; k < 3; k++) begin
      step(m_g4, '0, 1'b1);
      if (k == 2) check("nodb_g4", 32'(req), 32'(m_g4));
    end
    step('0, m_g4, 1'b1);
    check("nodb_clr_req", 32'(req), 32'h0);
    check("nodb_clr_any", 32'(any_req), 32'h0);
    idle();
`endif

    // Randomised traffic: slowly toggling buttons, glitches, sparse clears,
    // occasional reset.
    raw = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < BTN_N; b++)
        if ($urandom_range(0, DB_ON ? 30 : 4) == 0) raw[b] = ~raw[b];
      g    = ($urandom_range(0, 15) == 0) ? (10'(1) << $urandom_range(0, 9)) : '0;
      rb   = ($urandom_range(0, 5) == 0) ? 10'($urandom) : '0;
      rstn = ($urandom_range(0, 400) != 0);
      step(raw ^ g, rb, rstn);
    end

    done = 1'b1;
    @(posedge clk);
    #5;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
